// File: rtl/io_pkg.sv
// Shared I/O definitions: scan FSM state encoding, I/O word indices
// and a small zero-extension helper for the 5-bit switch banks.
package io_pkg;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_COMMIT = 2'd2
    } scan_state_e;

    localparam logic [5:0] IO_IN0_IDX    = 6'h00;
    localparam logic [5:0] IO_IN1_IDX    = 6'h01;
    localparam logic [5:0] IO_STATUS_IDX = 6'h02;

    function automatic logic [31:0] zext5(input logic [4:0] v);
        return {27'b0, v};
    endfunction

endpackage

// File: rtl/io_sync2.sv
// Two-flop synchronizer for a bus of asynchronous inputs.
// Ports: clk_i, rst_i (async, active-high), d_i raw, q_o synchronized.
module io_sync2 #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] s1_q;
    logic [W-1:0] s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule

// File: rtl/io_input_scan_ctrl.sv
// Round-robin switch scanner with one shared debounce counter.
// Ports: io_clk, reset; sw0/sw1 raw banks; addr/rd_en CPU I/O read;
// in_port0/in_port1 committed values; status {chg1,chg0}; chg_irq.
module io_input_scan_ctrl
    import io_pkg::*;
#(
    parameter int         DEB_CYCLES = 4,
    parameter int         CNT_W      = 16,
    parameter logic [5:0] STATUS_IDX = IO_STATUS_IDX
) (
    input  logic        io_clk,
    input  logic        reset,
    input  logic [4:0]  sw0,
    input  logic [4:0]  sw1,
    input  logic [31:0] addr,
    input  logic        rd_en,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [31:0] status,
    output logic        chg_irq
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [4:0] sync0;
    logic [4:0] sync1;

    io_sync2 #(.W(5)) u_sync0 (
        .clk_i (io_clk),
        .rst_i (reset),
        .d_i   (sw0),
        .q_o   (sync0)
    );

    io_sync2 #(.W(5)) u_sync1 (
        .clk_i (io_clk),
        .rst_i (reset),
        .d_i   (sw1),
        .q_o   (sync1)
    );

    scan_state_e      state_q, state_d;
    logic             sel_q, sel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       cand_q, cand_d;
    logic [4:0]       in0_q, in0_d;
    logic [4:0]       in1_q, in1_d;
    logic [1:0]       chg_q, chg_d;

    logic [4:0] raw_sel;
    logic [4:0] cur_sel;
    logic       rd_clr;
    logic       unused_addr;

    assign raw_sel     = sel_q ? sync1 : sync0;
    assign cur_sel     = sel_q ? in1_q : in0_q;
    assign rd_clr      = rd_en && (addr[7:2] == STATUS_IDX);
    assign unused_addr = ^{addr[31:8], addr[1:0]};

    always_ff @(posedge io_clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_SCAN;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            cand_q  <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            chg_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            chg_q   <= chg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        in0_d   = in0_q;
        in1_d   = in1_q;
        chg_d   = chg_q;

        // Clear first so a same-cycle commit below overrides it.
        if (rd_clr) begin
            chg_d = 2'b00;
        end

        case (state_q)
            ST_SCAN: begin
                if (raw_sel == cur_sel) begin
                    sel_d = ~sel_q;
                end else begin
                    cand_d  = raw_sel;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (raw_sel != cand_q) begin
                    cand_d = raw_sel;
                    cnt_d  = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_COMMIT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_COMMIT: begin
                if (sel_q) begin
                    in1_d = cand_q;
                end else begin
                    in0_d = cand_q;
                end
                chg_d[sel_q] = 1'b1;
                sel_d        = ~sel_q;
                state_d      = ST_SCAN;
            end
            default: begin
                state_d = ST_SCAN;
            end
        endcase
    end

    assign in_port0 = zext5(in0_q);
    assign in_port1 = zext5(in1_q);
    assign status   = {30'b0, chg_q};
    assign chg_irq  = |chg_q;

endmodule

// File: tb/tb_io_input_scan_ctrl.sv
// Self-checking bench for io_input_scan_ctrl: directed scenarios plus
// randomized switch activity checked against an abstract hold/commit model.
module tb_io_input_scan_ctrl;

    localparam int DEB = 4;
    localparam int HOLD = 20;

    logic        io_clk = 1'b0;
    logic        reset;
    logic [4:0]  sw0;
    logic [4:0]  sw1;
    logic [31:0] addr;
    logic        rd_en;
    logic [31:0] in_port0;
    logic [31:0] in_port1;
    logic [31:0] status;
    logic        chg_irq;

    int n_checks = 0;
    int n_errors = 0;

    io_input_scan_ctrl #(
        .DEB_CYCLES (DEB),
        .CNT_W      (16),
        .STATUS_IDX (6'h02)
    ) dut (
        .io_clk   (io_clk),
        .reset    (reset),
        .sw0      (sw0),
        .sw1      (sw1),
        .addr     (addr),
        .rd_en    (rd_en),
        .in_port0 (in_port0),
        .in_port1 (in_port1),
        .status   (status),
        .chg_irq  (chg_irq)
    );

    always #5 io_clk = ~io_clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge io_clk);
        #1;
    endtask

    // Raw switch history, one entry per clock edge.
    logic [4:0] h0 [64];
    logic [4:0] h1 [64];
    int         cyc = 0;

    always @(posedge io_clk) begin
        h0[cyc % 64] = sw0;
        h1[cyc % 64] = sw1;
        cyc = cyc + 1;
    end

    // True if v was held on the raw bank for DEB consecutive edges
    // somewhere in the recent past.
    function automatic bit held_recently(input int bank, input logic [4:0] v);
        for (int k = 0; k < 24; k++) begin
            bit ok = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                int idx = cyc - 1 - k - j;
                if (idx < 0) begin
                    ok = 1'b0;
                end else if (bank == 0 ? (h0[idx % 64] != v)
                                       : (h1[idx % 64] != v)) begin
                    ok = 1'b0;
                end
            end
            if (ok) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Every committed value must have been stably present on the switches.
    logic [31:0] prev0 = '0;
    logic [31:0] prev1 = '0;

    always @(negedge io_clk) begin
        if (!reset && in_port0 !== prev0) begin
            check("commit0_was_stable",
                  32'(held_recently(0, in_port0[4:0])), 32'd1);
        end
        if (!reset && in_port1 !== prev1) begin
            check("commit1_was_stable",
                  32'(held_recently(1, in_port1[4:0])), 32'd1);
        end
        prev0 = in_port0;
        prev1 = in_port1;
    end

    task automatic wait_port(input int bank, input logic [4:0] v);
        for (int i = 0; i < 14; i++) begin
            if (bank == 0 && in_port0[4:0] == v) break;
            if (bank == 1 && in_port1[4:0] == v) break;
            tick();
        end
    endtask

    task automatic read_status(input logic [31:0] a);
        rd_en = 1'b1;
        addr  = a;
        tick();
        rd_en = 1'b0;
        addr  = '0;
    endtask

    logic [4:0] m0, m1, nv0, nv1;
    bit         bounce;

    initial begin
        reset = 1'b1;
        sw0   = '0;
        sw1   = '0;
        addr  = '0;
        rd_en = 1'b0;
        repeat (3) tick();
        check("rst_in0", in_port0, 32'h0);
        check("rst_status", status, 32'h0);
        reset = 1'b0;

        // 1: idle
        repeat (50) tick();
        check("idle_in0", in_port0, 32'h0);
        check("idle_in1", in_port1, 32'h0);
        check("idle_status", status, 32'h0);
        check("idle_irq", 32'(chg_irq), 32'h0);

        // 2: single step on bank 0, worst-case 2 + 7 edges
        sw0 = 5'h15;
        repeat (9) tick();
        check("step_in0", in_port0, 32'h15);
        check("step_status", status, 32'h1);
        check("step_irq", 32'(chg_irq), 32'h1);
        check("step_in1", in_port1, 32'h0);
        read_status(32'h08);
        check("step_clear", status, 32'h0);

        // 3: bouncing bank 1 never commits until it holds
        for (int i = 0; i < 10; i++) begin
            sw1 = (i % 2 == 0) ? 5'h03 : 5'h00;
            repeat (2) tick();
        end
        check("bounce_in1", in_port1, 32'h0);
        check("bounce_status", status, 32'h0);
        sw1 = 5'h03;
        wait_port(1, 5'h03);
        check("hold_in1", in_port1, 32'h03);
        check("hold_status", status, 32'h2);

        // 4: status read decode
        sw0 = 5'h0A;
        wait_port(0, 5'h0A);
        tick();
        check("both_status", status, 32'h3);
        rd_en = 1'b1;
        addr  = 32'h04;
        #1;
        check("other_rd_pre", status, 32'h3);
        tick();
        rd_en = 1'b0;
        check("other_rd_post", status, 32'h3);
        rd_en = 1'b1;
        addr  = 32'h08;
        #1;
        check("stat_rd_pre", status, 32'h3);
        tick();
        rd_en = 1'b0;
        check("stat_rd_post", status, 32'h0);
        check("stat_rd_irq", 32'(chg_irq), 32'h0);

        // 5: commit coinciding with a status read, set wins
        sw1 = 5'h07;
        wait_port(1, 5'h07);
        tick();
        check("pre5_status", status, 32'h2);
        sw0   = 5'h0C;
        rd_en = 1'b1;
        addr  = 32'h08;
        wait_port(0, 5'h0C);
        rd_en = 1'b0;
        check("race_in0", in_port0, 32'h0C);
        check("race_status", status, 32'h1);
        tick();
        check("race_hold", status, 32'h1);

        // 6: reset mid-settle drops the pending commit
        read_status(32'h08);
        sw0 = 5'h1F;
        repeat (5) tick();
        reset = 1'b1;
        #1;
        check("mid_rst_in0", in_port0, 32'h0);
        check("mid_rst_status", status, 32'h0);
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check("redeb_early", in_port0, 32'h0);
        wait_port(0, 5'h1F);
        check("redeb_in0", in_port0, 32'h1F);
        repeat (HOLD) tick();

        // Random activity: abstract model only tracks committed values
        m0 = in_port0[4:0];
        m1 = in_port1[4:0];
        check("rand_start_in1", in_port1, 32'h07);
        for (int it = 0; it < 30; it++) begin
            read_status(32'h08);
            check("rand_clear", status, 32'h0);
            nv0 = ($urandom_range(0, 3) == 0) ? m0 : 5'($urandom);
            nv1 = ($urandom_range(0, 3) == 0) ? m1 : 5'($urandom);
            bounce = $urandom_range(0, 1) == 1;
            if (bounce) begin
                repeat ($urandom_range(1, 5)) begin
                    sw0 = 5'($urandom);
                    sw1 = 5'($urandom);
                    tick();
                end
            end
            sw0 = nv0;
            sw1 = nv1;
            repeat (HOLD) tick();
            check("rand_in0", in_port0, 32'(nv0));
            check("rand_in1", in_port1, 32'(nv1));
            if (!bounce) begin
                check("rand_status", status,
                      {30'b0, nv1 != m1, nv0 != m0});
            end else begin
                if (nv0 != m0) check("rand_chg0", 32'(status[0]), 32'h1);
                if (nv1 != m1) check("rand_chg1", 32'(status[1]), 32'h1);
            end
            m0 = nv0;
            m1 = nv1;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
